// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART command parser.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_SEP,
        S_LEN,
        S_EOL,
        S_RDREQ,
        S_RDWAIT,
        S_TXREQ,
        S_TXWAIT,
        S_ERR
    } state_t;

    // What the byte currently in the tx handshake is, so TXWAIT knows where to go next.
    typedef enum logic [1:0] {
        TX_DATA,
        TX_ERR,
        TX_ECHO
    } tx_kind_t;

    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_R_LC  = 8'h72;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_QMARK = 8'h3F;

    function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
        logic [4:0] res;
        res = 5'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, ch[3:0]};
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            res = {1'b1, ch[3:0] + 4'd9};
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_ascii_decode
    import uart_cmd_pkg::*;
(
    input  logic [7:0] ch,
    output logic       valid,
    output logic [3:0] nibble
);

    assign {valid, nibble} = hex_nibble(ch);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "Raaaaaa,ll<CR|LF>" from uart_rx, reads flash byte by byte and streams bytes to uart_tx.
// Optional feature macro CMD_ECHO_EN: echo every consumed command character to uart_tx.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_read,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic [7:0]        rd_data,
    output logic              tx_write,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy
);

    localparam logic [3:0] LAST_ADDR_DIGIT = 4'(ADDR_W / 4 - 1);

    state_t   state, state_next, parse_next, ret_state;
    tx_kind_t tx_kind;
    logic [8:0] count;
    logic [3:0] digit_cnt;
    logic       first_wait;
    logic       hex_valid;
    logic [3:0] hex_val;
    logic       in_cmd, is_eol, timeout_hit, tx_done;

    hex_ascii_decode u_hex (
        .ch     (rx_data),
        .valid  (hex_valid),
        .nibble (hex_val)
    );

    assign in_cmd   = state inside {S_ADDR, S_SEP, S_LEN, S_EOL};
    assign rx_read  = rx_valid && (in_cmd || state == S_IDLE);
    assign is_eol   = (rx_data == CH_CR) || (rx_data == CH_LF);
    assign tx_done  = (state == S_TXWAIT) && !first_wait && tx_ready;
    assign rd_req   = (state == S_RDREQ);
    assign tx_write = (state == S_TXREQ) && tx_ready;
    assign busy     = (state != S_IDLE);

    generate
        if (IDLE_TIMEOUT > 0) begin : g_timeout
            logic [31:0] idle_cnt;
            always_ff @(posedge clk) begin
                if (rst || rx_read || !in_cmd) idle_cnt <= '0;
                else                           idle_cnt <= idle_cnt + 32'd1;
            end
            assign timeout_hit = in_cmd && !rx_valid && (idle_cnt == 32'(IDLE_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // parse_next is where the command grammar goes; the echo path parks it in ret_state.
    always_comb begin
        parse_next = state;
        case (state)
            S_IDLE: if (rx_valid) begin
                if (rx_data == CH_R || rx_data == CH_R_LC) parse_next = S_ADDR;
                else if (!(is_eol || rx_data == CH_SPACE)) parse_next = S_ERR;
            end
            S_ADDR: if (rx_valid) begin
                if (!hex_valid)                         parse_next = S_ERR;
                else if (digit_cnt == LAST_ADDR_DIGIT)  parse_next = S_SEP;
            end
            S_SEP:  if (rx_valid) parse_next = (rx_data == CH_COMMA) ? S_LEN : S_ERR;
            S_LEN: if (rx_valid) begin
                if (!hex_valid)              parse_next = S_ERR;
                else if (digit_cnt == 4'd1)  parse_next = S_EOL;
            end
            S_EOL:  if (rx_valid) parse_next = is_eol ? S_RDREQ : S_ERR;
            default: ;
        endcase
        if (timeout_hit) parse_next = S_ERR;

        state_next = parse_next;
        case (state)
            S_RDREQ:  state_next = S_RDWAIT;
            S_RDWAIT: if (rd_ready) state_next = S_TXREQ;
            S_TXREQ:  if (tx_ready) state_next = S_TXWAIT;
            S_TXWAIT: if (tx_done) begin
                case (tx_kind)
                    TX_DATA: state_next = (count == 9'd1) ? S_IDLE : S_RDREQ;
                    TX_ECHO: state_next = ret_state;
                    default: state_next = S_IDLE;
                endcase
            end
            S_ERR:    state_next = S_TXREQ;
            default: ;
        endcase
`ifdef CMD_ECHO_EN
        if (rx_read) state_next = S_TXREQ;
`endif
    end

    // Length 00 is widened to 256 when the line terminator arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            tx_data    <= '0;
            count      <= '0;
            digit_cnt  <= '0;
            first_wait <= 1'b0;
            tx_kind    <= TX_DATA;
            ret_state  <= S_IDLE;
        end else begin
            first_wait <= (state == S_TXREQ);
            case (state)
                S_IDLE: if (rx_read) digit_cnt <= '0;
                S_ADDR: if (rx_read && hex_valid) begin
                    rd_addr   <= {rd_addr[ADDR_W-5:0], hex_val};
                    digit_cnt <= (digit_cnt == LAST_ADDR_DIGIT) ? 4'd0 : digit_cnt + 4'd1;
                end
                S_LEN: if (rx_read && hex_valid) begin
                    count     <= {1'b0, count[3:0], hex_val};
                    digit_cnt <= digit_cnt + 4'd1;
                end
                S_EOL: if (rx_read && is_eol && count[7:0] == 8'd0) count <= 9'd256;
                S_RDREQ:  tx_kind <= TX_DATA;
                S_RDWAIT: if (rd_ready) tx_data <= rd_data;
                S_TXWAIT: if (tx_done && tx_kind == TX_DATA) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    count   <= count - 9'd1;
                end
                S_ERR: begin
                    tx_data <= CH_QMARK;
                    tx_kind <= TX_ERR;
                end
                default: ;
            endcase
`ifdef CMD_ECHO_EN
            if (rx_read) begin
                tx_data   <= rx_data;
                tx_kind   <= TX_ECHO;
                ret_state <= parse_next;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed and random commands vs a string-level model.
module tb_uart_cmd_parser;

    localparam int TIMEOUT = 1000;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_read;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [23:0] rd_log[$];
    logic [23:0] exp_rd[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  cmd[$];

    int          flash_cnt = 0;
    logic        flash_busy = 1'b0;
    logic [23:0] flash_addr = '0;
    int          tx_hold;

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .ADDR_W       (24),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_read  (rx_read),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .tx_write (tx_write),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    // Flash reader: no reset, answers every request 30 clocks later with A[7:0]^5A.
    always @(posedge clk) begin
        rd_ready <= 1'b0;
        if (flash_busy) begin
            if (flash_cnt == 29) begin
                rd_ready   <= 1'b1;
                rd_data    <= flash_addr[7:0] ^ 8'h5A;
                flash_busy <= 1'b0;
            end else begin
                flash_cnt <= flash_cnt + 1;
            end
        end
        if (rd_req) begin
            flash_busy <= 1'b1;
            flash_cnt  <= 0;
            flash_addr <= rd_addr;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            tx_ready <= 1'b1;
            tx_hold  <= 0;
        end else if (tx_write) begin
            tx_ready <= 1'b0;
            tx_hold  <= $urandom_range(2, 9);
        end else if (tx_hold > 0) begin
            tx_hold <= tx_hold - 1;
        end else begin
            tx_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_req)   rd_log.push_back(rd_addr);
        if (!rst && tx_write) tx_log.push_back(tx_data);
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input int v);
        if (v < 10) return 8'(48 + v);
        return ($urandom_range(0, 1) == 1) ? 8'(55 + v) : 8'(87 + v);
    endfunction

    // Reads the command text field by field and appends the expected reads and tx bytes.
    task automatic model_cmd();
        int pos = 0;
        int addr = 0;
        int len = 0;
        int v;
        logic [7:0] c;
        for (int i = 0; i < cmd.size(); i++) begin
            c = cmd[i];
            v = hexval(c);
`ifdef CMD_ECHO_EN
            exp_tx.push_back(c);
`endif
            if (pos == 0) begin
                if (c == 8'h52 || c == 8'h72) begin
                    pos  = 1;
                    addr = 0;
                end else if (!(c == CR || c == LF || c == 8'h20)) begin
                    exp_tx.push_back(8'h3F);
                end
            end else if (pos <= 6 || pos == 8 || pos == 9) begin
                if (v < 0) begin
                    exp_tx.push_back(8'h3F);
                    pos = 0;
                end else begin
                    if (pos <= 6) addr = addr * 16 + v;
                    else          len  = len * 16 + v;
                    pos++;
                end
            end else if (pos == 7) begin
                if (c == 8'h2C) begin
                    pos = 8;
                    len = 0;
                end else begin
                    exp_tx.push_back(8'h3F);
                    pos = 0;
                end
            end else begin
                if (c == CR || c == LF) begin
                    if (len == 0) len = 256;
                    for (int k = 0; k < len; k++) begin
                        v = (addr + k) % (1 << 24);
                        exp_rd.push_back(24'(v));
                        exp_tx.push_back(8'(v % 256) ^ 8'h5A);
                    end
                end else begin
                    exp_tx.push_back(8'h3F);
                end
                pos = 0;
            end
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) cmd.push_back(s[i]);
    endtask

    task automatic send_char(input logic [7:0] c);
        bit got = 1'b0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = c;
        for (int n = 0; n < 20000; n++) begin
            #1;
            if (rx_read) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check_output("rx_accept", 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_output("idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_logs(input string tag);
        check_output({tag, "_rd_count"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            check_output($sformatf("%s_rd%0d", tag, i), 32'(rd_log[i]), 32'(exp_rd[i]));
        check_output({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            check_output($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
    endtask

    task automatic clear_logs();
        rd_log.delete();
        tx_log.delete();
        exp_rd.delete();
        exp_tx.delete();
    endtask

    task automatic apply_stimulus(input string tag);
        clear_logs();
        model_cmd();
        for (int i = 0; i < cmd.size(); i++) begin
            send_char(cmd[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(20000);
        compare_logs(tag);
    endtask

    initial begin
        int n;
        int addr;
        int len;
        int start;
        int bad;
        logic [7:0] badc;

        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rd_req", 32'(rd_req), 32'd0);
        check_output("rst_tx_write", 32'(tx_write), 32'd0);
        check_output("rst_rd_addr", 32'(rd_addr), 32'd0);
        check_output("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_rx_read", 32'(rx_read), 32'd0);

        cmd.delete(); push_str("R400000,03"); cmd.push_back(CR);
        apply_stimulus("three");
        check_output("three_final_addr", 32'(rd_addr), 32'h400003);

        cmd.delete(); push_str("r40000a,00"); cmd.push_back(LF);
        apply_stimulus("len256");

        cmd.delete(); push_str("RFFFFFF,02"); cmd.push_back(CR);
        apply_stimulus("wrap");

        cmd.delete(); push_str("R40G");
        apply_stimulus("bad_hex");
        cmd.delete(); push_str("R400001,01"); cmd.push_back(CR);
        apply_stimulus("after_err");

        // Stalled command must time out into a '?'.
        cmd.delete(); push_str("R40");
        clear_logs();
        model_cmd();
        exp_tx.push_back(8'h3F);
        for (int i = 0; i < cmd.size(); i++) send_char(cmd[i]);
        n = 0;
        while (tx_log.size() < exp_tx.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_output("timeout_window", 32'(n >= 990 && n <= 1040), 32'd1);
        wait_idle(200);
        compare_logs("timeout");

        // Reset in RDWAIT; the flash's late answer must not reach tx.
        cmd.delete(); push_str("R400000,05"); cmd.push_back(CR);
        clear_logs();
        for (int i = 0; i < cmd.size(); i++) send_char(cmd[i]);
        n = 0;
        while (rd_log.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        #1;
        check_output("held_rx_read", 32'(rx_read), 32'd0);
        rx_valid = 1'b0;
        tx_log.delete();
        rst = 1'b1;
        @(negedge clk);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_rd_req", 32'(rd_req), 32'd0);
        check_output("mid_rst_tx_write", 32'(tx_write), 32'd0);
        check_output("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        check_output("mid_rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check_output("mid_rst_no_tx", tx_log.size(), 32'd0);
        check_output("mid_rst_one_read", rd_log.size(), 32'd1);
        check_output("mid_rst_still_idle", 32'(busy), 32'd0);

        for (int t = 0; t < 12; t++) begin
            cmd.delete();
            if ($urandom_range(0, 3) == 0) cmd.push_back(($urandom_range(0, 1) == 1) ? 8'h20 : LF);
            start = cmd.size();
            if ($urandom_range(0, 3) == 0) addr = 'hFFFFFF - int'($urandom_range(0, 2));
            else                           addr = int'($urandom & 32'hFFFFFF);
            len = $urandom_range(1, 4);
            cmd.push_back(($urandom_range(0, 1) == 1) ? 8'h52 : 8'h72);
            for (int d = 5; d >= 0; d--) cmd.push_back(hexchar((addr >> (4 * d)) & 15));
            cmd.push_back(8'h2C);
            cmd.push_back(hexchar(len >> 4));
            cmd.push_back(hexchar(len & 15));
            cmd.push_back(($urandom_range(0, 1) == 1) ? CR : LF);
            if ($urandom_range(0, 4) == 0) begin
                bad = start + $urandom_range(0, 10);
                case ($urandom_range(0, 2))
                    0:       badc = 8'h47;
                    1:       badc = 8'h78;
                    default: badc = 8'h23;
                endcase
                cmd[bad] = badc;
                while (cmd.size() > bad + 1) void'(cmd.pop_back());
            end
            apply_stimulus($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
